// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master that fetches a contiguous run of 32-bit words into a FIFO
// and hands them out on one of four router lanes with a valid/next handshake.
module painterengine_gpu_dma_reader #(
    parameter int PARAM_DATA_ALIGN = 16,
    parameter int PARAM_FIFO_DEPTH = 64
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_reset,
    input  logic [3:0]   i_wire_router,
    output logic         o_wire_done,
    output logic         o_wire_error,
    input  logic [127:0] i_wire_address,
    input  logic [127:0] i_wire_length,
    output logic [127:0] o_wire_data,
    output logic [3:0]   o_wire_data_valid,
    input  logic [3:0]   i_wire_data_next,
    output logic         o_wire_M_AXI_ARID,
    output logic [31:0]  o_wire_M_AXI_ARADDR,
    output logic [7:0]   o_wire_M_AXI_ARLEN,
    output logic [2:0]   o_wire_M_AXI_ARSIZE,
    output logic [1:0]   o_wire_M_AXI_ARBURST,
    output logic         o_wire_M_AXI_ARLOCK,
    output logic [3:0]   o_wire_M_AXI_ARCACHE,
    output logic [2:0]   o_wire_M_AXI_ARPROT,
    output logic [3:0]   o_wire_M_AXI_ARQOS,
    output logic         o_wire_M_AXI_ARVALID,
    input  logic         i_wire_M_AXI_ARREADY,
    input  logic         i_wire_M_AXI_RID,
    input  logic [31:0]  i_wire_M_AXI_RDATA,
    input  logic [1:0]   i_wire_M_AXI_RRESP,
    input  logic         i_wire_M_AXI_RLAST,
    input  logic         i_wire_M_AXI_RVALID,
    output logic         o_wire_M_AXI_RREADY
);
    localparam int PTR_W = $clog2(PARAM_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       len_q, len_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       offset_q, offset_d;
    logic [8:0]        beat_q, beat_d;
    logic [8:0]        burst_q, burst_d;
    logic [15:0]       timeout_q, timeout_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       fifo_mem [PARAM_FIFO_DEPTH];

    logic [1:0]  lane_sel;
    logic        router_onehot;
    logic [31:0] word_pos, align_room, remain, burst_full, fifo_space;
    logic [8:0]  burst_len;
    logic        active, ar_valid, ar_hs, r_ready, r_beat, fifo_valid, push, pop, last_beat;
    logic        unused_bits;

    always_comb begin
        lane_sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (i_wire_router[k]) lane_sel = 2'(k);
        end
    end

    assign router_onehot = (i_wire_router != 4'b0) &&
                           ((i_wire_router & (i_wire_router - 4'd1)) == 4'b0);

    // Burst is clipped at the next alignment boundary and at the end of the run.
    assign word_pos   = (addr_q >> 2) + offset_q;
    assign align_room = 32'(PARAM_DATA_ALIGN) - (word_pos & 32'(PARAM_DATA_ALIGN - 1));
    assign remain     = len_q - offset_q;
    assign burst_full = (align_room < remain) ? align_room : remain;
    assign burst_len  = burst_full[8:0];
    assign fifo_space = 32'(PARAM_FIFO_DEPTH) - 32'(count_q);

    assign active     = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_DRAIN);
    assign ar_valid   = (state_q == S_ADDR) && (fifo_space >= 32'(burst_len));
    assign ar_hs      = ar_valid && i_wire_M_AXI_ARREADY;
    assign r_ready    = (state_q == S_DATA);
    assign r_beat     = r_ready && i_wire_M_AXI_RVALID;
    assign fifo_valid = active && (count_q != '0);
    assign push       = r_beat;
    assign pop        = fifo_valid && i_wire_data_next[lane_q];
    assign last_beat  = (beat_q == burst_q - 9'd1);

    assign o_wire_M_AXI_ARID    = 1'b0;
    assign o_wire_M_AXI_ARADDR  = addr_q + (offset_q << 2);
    assign o_wire_M_AXI_ARLEN   = 8'(burst_len - 9'd1);
    assign o_wire_M_AXI_ARSIZE  = 3'b010;
    assign o_wire_M_AXI_ARBURST = 2'b01;
    assign o_wire_M_AXI_ARLOCK  = 1'b0;
    assign o_wire_M_AXI_ARCACHE = 4'b0010;
    assign o_wire_M_AXI_ARPROT  = 3'b000;
    assign o_wire_M_AXI_ARQOS   = 4'b0000;
    assign o_wire_M_AXI_ARVALID = ar_valid;
    assign o_wire_M_AXI_RREADY  = r_ready;
    assign o_wire_done          = (state_q == S_DONE);
    assign o_wire_error         = (state_q == S_ERROR);
    assign unused_bits          = &{1'b0, i_wire_M_AXI_RID, burst_full[31:9]};

    always_comb begin
        o_wire_data       = '0;
        o_wire_data_valid = '0;
        if (fifo_valid) begin
            o_wire_data[{lane_q, 5'b0} +: 32] = fifo_mem[rd_ptr_q];
            o_wire_data_valid[lane_q]        = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        lane_d    = lane_q;
        offset_d  = offset_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        timeout_d = timeout_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_IDLE: begin
                addr_d = i_wire_address[{lane_sel, 5'b0} +: 32];
                len_d  = i_wire_length[{lane_sel, 5'b0} +: 32];
                lane_d = lane_sel;
                if (!router_onehot || (i_wire_address[{lane_sel, 5'b0} +: 2] != 2'b00) ||
                    (i_wire_length[{lane_sel, 5'b0} +: 32] == 32'd0)) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ar_hs) begin
                    offset_d = offset_q + 32'(burst_len);
                    beat_d   = '0;
                    burst_d  = burst_len;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (r_beat) begin
                    beat_d = beat_q + 9'd1;
                    if (i_wire_M_AXI_RRESP >= 2'b10) begin
                        state_d = S_ERROR;
                    end else if (i_wire_M_AXI_RLAST != last_beat) begin
                        state_d = S_ERROR;
                    end else if (last_beat) begin
                        state_d = (offset_q < len_q) ? S_ADDR : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (count_q == '0) state_d = S_DONE;
            end
            default: ;
        endcase

        // Any forward progress restarts the watchdog; a stall that long is fatal.
        if (active) begin
            if (ar_hs || r_beat || pop) timeout_d = '0;
            else                        timeout_d = timeout_q + 16'd1;
            if (timeout_q == 16'hFFFF) state_d = S_ERROR;
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            lane_q    <= '0;
            offset_q  <= '0;
            beat_q    <= '0;
            burst_q   <= '0;
            timeout_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            lane_q    <= lane_d;
            offset_q  <= offset_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            timeout_q <= timeout_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (push) fifo_mem[wr_ptr_q] <= i_wire_M_AXI_RDATA;
    end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for painterengine_gpu_dma_reader: randomized AXI slave and consumer,
// checked against a word-by-word model of the expected bursts and data.
`timescale 1ns/1ps
module tb_painterengine_gpu_dma_reader;
    localparam int ALIGN = 16;
    localparam int DEPTH = 64;

    logic         clock = 1'b0;
    logic         i_wire_reset;
    logic [3:0]   i_wire_router;
    logic         o_wire_done, o_wire_error;
    logic [127:0] i_wire_address, i_wire_length;
    logic [127:0] o_wire_data;
    logic [3:0]   o_wire_data_valid, i_wire_data_next;
    logic         o_arid, o_arlock, o_arvalid, o_rready;
    logic [31:0]  o_araddr;
    logic [7:0]   o_arlen;
    logic [2:0]   o_arsize, o_arprot;
    logic [1:0]   o_arburst;
    logic [3:0]   o_arcache, o_arqos;
    logic         i_arready, i_rid, i_rlast, i_rvalid;
    logic [31:0]  i_rdata;
    logic [1:0]   i_rresp;

    always #5 clock = ~clock;

    painterengine_gpu_dma_reader #(.PARAM_DATA_ALIGN(ALIGN), .PARAM_FIFO_DEPTH(DEPTH)) dut (
        .i_wire_clock(clock), .i_wire_reset(i_wire_reset), .i_wire_router(i_wire_router),
        .o_wire_done(o_wire_done), .o_wire_error(o_wire_error),
        .i_wire_address(i_wire_address), .i_wire_length(i_wire_length),
        .o_wire_data(o_wire_data), .o_wire_data_valid(o_wire_data_valid),
        .i_wire_data_next(i_wire_data_next),
        .o_wire_M_AXI_ARID(o_arid), .o_wire_M_AXI_ARADDR(o_araddr), .o_wire_M_AXI_ARLEN(o_arlen),
        .o_wire_M_AXI_ARSIZE(o_arsize), .o_wire_M_AXI_ARBURST(o_arburst),
        .o_wire_M_AXI_ARLOCK(o_arlock), .o_wire_M_AXI_ARCACHE(o_arcache),
        .o_wire_M_AXI_ARPROT(o_arprot), .o_wire_M_AXI_ARQOS(o_arqos),
        .o_wire_M_AXI_ARVALID(o_arvalid), .i_wire_M_AXI_ARREADY(i_arready),
        .i_wire_M_AXI_RID(i_rid), .i_wire_M_AXI_RDATA(i_rdata), .i_wire_M_AXI_RRESP(i_rresp),
        .i_wire_M_AXI_RLAST(i_rlast), .i_wire_M_AXI_RVALID(i_rvalid),
        .o_wire_M_AXI_RREADY(o_rready)
    );

    typedef struct {
        logic [31:0] addr;
        int          cnt;
    } burst_t;

    typedef struct {
        logic [3:0]  router;
        logic [31:0] addr;
        logic [31:0] len;
        bit          badStart;
        bit          expErr;
        int          badResp;
        int          earlyLast;
        int          expArs;
        int          pct;
    } vec_t;

    burst_t      expAr[$];
    burst_t      pend[$];
    logic [31:0] expWords[$];
    int beatIdx, globalBeat, arCount, popCount, expArTotal, expWordTotal;
    int arReadyPct, rValidPct, nextPct, badResp, earlyLast, laneIdx;
    logic [3:0] laneMask;
    int total = 0;
    int bad = 0;

    function automatic logic [31:0] memWord(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic vec_t mk(logic [3:0] r, logic [31:0] a, logic [31:0] l, bit bs, bit ee,
                                int br, int el, int ea, int pct);
        vec_t v;
        v.router = r; v.addr = a; v.len = l; v.badStart = bs; v.expErr = ee;
        v.badResp = br; v.earlyLast = el; v.expArs = ea; v.pct = pct;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Walk the run word by word; a new burst starts at the first word and at every boundary.
    task automatic buildModel(logic [31:0] addr, logic [31:0] len);
        burst_t b;
        logic [31:0] wa;
        expAr.delete();
        expWords.delete();
        for (int i = 0; i < int'(len); i++) begin
            wa = addr + 32'(4 * i);
            expWords.push_back(memWord(wa));
            if (i == 0 || ((wa >> 2) & 32'(ALIGN - 1)) == 0) begin
                b.addr = wa; b.cnt = 1;
                expAr.push_back(b);
            end else begin
                b = expAr.pop_back();
                b.cnt++;
                expAr.push_back(b);
            end
        end
        expArTotal = expAr.size();
        expWordTotal = expWords.size();
    endtask

    task automatic stepCycle();
        logic [127:0] dm;
        logic [3:0]   nx;
        bit           arr, rv;
        burst_t       b;
        @(negedge clock);
        checkOutput("valid_other_lanes", 64'(o_wire_data_valid & ~laneMask), 64'd0);
        dm = o_wire_data;
        for (int k = 0; k < 4; k++) if (laneMask[k]) dm[32*k +: 32] = '0;
        checkOutput("data_other_lanes", 64'(dm != '0), 64'd0);

        if (pend.size() > 0) begin
            b = pend[0];
            rv = ($urandom_range(99) < rValidPct);
            i_rvalid = rv;
            i_rdata  = memWord(b.addr + 32'(4 * beatIdx));
            i_rlast  = (beatIdx == b.cnt - 1) ^ (globalBeat == earlyLast);
            i_rresp  = (globalBeat == badResp) ? 2'b10 : 2'b00;
            if (rv && o_rready) begin
                beatIdx++;
                globalBeat++;
                if (beatIdx == b.cnt) begin
                    void'(pend.pop_front());
                    beatIdx = 0;
                end
            end
        end else begin
            i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00; i_rdata = '0;
        end

        arr = ($urandom_range(99) < arReadyPct);
        i_arready = arr;
        if (o_arvalid && arr) begin
            arCount++;
            checkOutput("ar_constants",
                        64'({o_arid, o_arsize, o_arburst, o_arlock, o_arcache, o_arprot, o_arqos}),
                        64'({1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000}));
            if (expAr.size() == 0) begin
                checkOutput("ar_extra", 64'(arCount), 64'(expArTotal));
            end else begin
                b = expAr.pop_front();
                checkOutput("ar_addr", 64'(o_araddr), 64'(b.addr));
                checkOutput("ar_len", 64'(o_arlen), 64'(b.cnt - 1));
            end
            b.addr = o_araddr;
            b.cnt  = int'(o_arlen) + 1;
            pend.push_back(b);
        end

        nx = 4'($urandom);
        if (laneMask != 4'b0) nx[laneIdx] = ($urandom_range(99) < nextPct);
        i_wire_data_next = nx;
        if (laneMask != 4'b0 && o_wire_data_valid[laneIdx] && nx[laneIdx]) begin
            popCount++;
            if (expWords.size() == 0)
                checkOutput("pop_extra", 64'(popCount), 64'(expWordTotal));
            else
                checkOutput("pop_data", 64'(o_wire_data[32*laneIdx +: 32]), 64'(expWords.pop_front()));
        end
    endtask

    task automatic checkAllZero(string tag);
        checkOutput({tag, "_done"},   64'(o_wire_done), 64'd0);
        checkOutput({tag, "_error"},  64'(o_wire_error), 64'd0);
        checkOutput({tag, "_arvalid"}, 64'(o_arvalid), 64'd0);
        checkOutput({tag, "_rready"}, 64'(o_rready), 64'd0);
        checkOutput({tag, "_valid"},  64'(o_wire_data_valid), 64'd0);
        checkOutput({tag, "_data"},   64'(o_wire_data != '0), 64'd0);
    endtask

    task automatic startTransfer(vec_t v);
        i_wire_reset = 1'b1;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00; i_rdata = '0;
        i_rid = 1'b0; i_wire_data_next = 4'b0;
        pend.delete();
        beatIdx = 0; globalBeat = 0; arCount = 0; popCount = 0;
        laneMask = $onehot(v.router) ? v.router : 4'b0;
        laneIdx = 0;
        for (int k = 0; k < 4; k++) begin
            if (v.router[k]) begin
                laneIdx = k;
                i_wire_address[32*k +: 32] = v.addr;
                i_wire_length[32*k +: 32]  = v.len;
            end else begin
                i_wire_address[32*k +: 32] = $urandom;
                i_wire_length[32*k +: 32]  = $urandom;
            end
        end
        i_wire_router = v.router;
        arReadyPct = v.pct; rValidPct = v.pct; nextPct = v.pct;
        badResp = v.badResp; earlyLast = v.earlyLast;
        buildModel(v.addr, v.len);
        repeat (2) @(negedge clock);
        checkAllZero("reset");
        i_wire_reset = 1'b0;
        stepCycle();
        checkOutput("start_error", 64'(o_wire_error), 64'(v.badStart));
    endtask

    task automatic runToEnd(int budget);
        int c = 0;
        while (!(o_wire_done || o_wire_error) && c < budget) begin
            stepCycle();
            c++;
        end
        checkOutput("finished_in_budget", 64'(o_wire_done | o_wire_error), 64'd1);
    endtask

    task automatic finishCheck(vec_t v);
        repeat (10) stepCycle();
        checkOutput("done", 64'(o_wire_done), 64'(!v.expErr));
        checkOutput("error", 64'(o_wire_error), 64'(v.expErr));
        checkOutput("ar_count", 64'(arCount), 64'((v.expArs < 0) ? expArTotal : v.expArs));
        if (!v.expErr) checkOutput("words_left", 64'(expWords.size()), 64'd0);
        checkOutput("end_arvalid", 64'(o_arvalid), 64'd0);
        checkOutput("end_rready", 64'(o_rready), 64'd0);
        checkOutput("end_valid", 64'(o_wire_data_valid), 64'd0);
    endtask

    task automatic applyStimulus(vec_t v);
        startTransfer(v);
        runToEnd(5000);
        finishCheck(v);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int c;
        i_wire_reset = 1'b1;
        i_wire_router = 4'b0; i_wire_address = '0; i_wire_length = '0; i_wire_data_next = 4'b0;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00; i_rdata = '0; i_rid = 1'b0;
        laneMask = 4'b0; laneIdx = 0;

        tbl.push_back(mk(4'b0001, 32'h1000, 32'd5,  0, 0, -1, -1, -1, 100));
        tbl.push_back(mk(4'b0100, 32'h1038, 32'd20, 0, 0, -1, -1, -1, 100));
        tbl.push_back(mk(4'b0010, 32'h2004, 32'd37, 0, 0, -1, -1, -1, 50));
        tbl.push_back(mk(4'b0100, 32'h103C, 32'd1,  0, 0, -1, -1, -1, 70));
        tbl.push_back(mk(4'b1000, 32'h10FC, 32'd2,  0, 0, -1, -1, -1, 60));
        tbl.push_back(mk(4'b0001, 32'h1002, 32'd5,  1, 1, -1, -1, 0, 100));
        tbl.push_back(mk(4'b1000, 32'h1000, 32'd0,  1, 1, -1, -1, 0, 100));
        tbl.push_back(mk(4'b0011, 32'h1000, 32'd5,  1, 1, -1, -1, 0, 100));
        tbl.push_back(mk(4'b0000, 32'h1000, 32'd5,  1, 1, -1, -1, 0, 100));
        tbl.push_back(mk(4'b0001, 32'h3000, 32'd40, 0, 1, 2, -1, 1, 100));
        tbl.push_back(mk(4'b1000, 32'h3030, 32'd20, 0, 1, -1, 1, 1, 100));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(4'b0001 << $urandom_range(0, 3),
                             32'h4000 + 32'($urandom_range(0, 4095)) * 4,
                             32'($urandom_range(1, 150)), 0, 0, -1, -1, -1,
                             int'($urandom_range(30, 100))));
        end
        foreach (tbl[i]) applyStimulus(tbl[i]);

        v = mk(4'b0001, 32'h2000, 32'd100, 0, 0, -1, -1, -1, 100);
        startTransfer(v);
        nextPct = 0;
        repeat (300) stepCycle();
        checkOutput("bp_ar_count", 64'(arCount), 64'd4);
        checkOutput("bp_pops", 64'(popCount), 64'd0);
        checkOutput("bp_arvalid", 64'(o_arvalid), 64'd0);
        checkOutput("bp_valid", 64'(o_wire_data_valid[0]), 64'd1);
        nextPct = 100;
        runToEnd(5000);
        finishCheck(v);

        v = mk(4'b0010, 32'h5000, 32'd40, 0, 0, -1, -1, -1, 100);
        startTransfer(v);
        nextPct = 0;
        c = 0;
        while (globalBeat < 3 && c < 200) begin
            stepCycle();
            c++;
        end
        checkOutput("mid_reached_data", 64'(o_rready), 64'd1);
        @(negedge clock);
        i_wire_reset = 1'b1;
        i_rvalid = 1'b0; i_arready = 1'b0;
        @(negedge clock);
        checkAllZero("mid_reset");
        applyStimulus(mk(4'b0010, 32'h5100, 32'd23, 0, 0, -1, -1, -1, 80));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/painterengine_gpu_dma_reader.md
Name: painterengine_gpu_dma_reader

Overview:
- AXI4 full read master; the read-side counterpart of the GPU DMA writer.
- Fetches a contiguous run of 32-bit words from memory into an internal FIFO.
- Presents the words in order on one of four router lanes to GPU consumers, using the valid/next handshake.
- One transfer per reset cycle. done and error are sticky until reset.

Parameters:
- PARAM_DATA_ALIGN, 16, burst alignment in 32-bit beats; power of two, 1..256. No burst crosses a PARAM_DATA_ALIGN-beat boundary.
- PARAM_FIFO_DEPTH, 64, internal FIFO depth in words; power of two, must be ≥ PARAM_DATA_ALIGN.

Ports:
- i_wire_clock  in  1  clock
- i_wire_reset  in  1  synchronous active-high reset
- i_wire_router  in  4  one-hot lane select; lane index k = bit position
- o_wire_done  out  1  transfer complete and all words consumed
- o_wire_error  out  1  sticky error
- i_wire_address  in  128  per-lane byte start address, lane k at [32k+:32]
- i_wire_length  in  128  per-lane length in words, lane k at [32k+:32]
- o_wire_data  out  128  FIFO head word on selected lane slice; other slices 0
- o_wire_data_valid  out  4  selected bit = FIFO non-empty, only in read/drain states
- i_wire_data_next  in  4  consumer pop; honoured only where valid
- o_wire_M_AXI_ARID  out  1  constant 0
- o_wire_M_AXI_ARADDR  out  32  burst byte address
- o_wire_M_AXI_ARLEN  out  8  burst length minus 1
- o_wire_M_AXI_ARSIZE  out  3  3'b010
- o_wire_M_AXI_ARBURST  out  2  2'b01
- o_wire_M_AXI_ARLOCK  out  1  0
- o_wire_M_AXI_ARCACHE  out  4  4'b0010
- o_wire_M_AXI_ARPROT  out  3  0
- o_wire_M_AXI_ARQOS  out  4  0
- o_wire_M_AXI_ARVALID  out  1  address valid
- i_wire_M_AXI_ARREADY  in  1
- i_wire_M_AXI_RID  in  1  ignored
- i_wire_M_AXI_RDATA  in  32
- i_wire_M_AXI_RRESP  in  2
- i_wire_M_AXI_RLAST  in  1
- i_wire_M_AXI_RVALID  in  1
- o_wire_M_AXI_RREADY  out  1

Behaviour:
- Reset:
  - Synchronous: all registers, FIFO pointers, counters and outputs clear to 0; state is IDLE.
  - Reset mid-transfer abandons the transfer with no AXI cleanup.
- States: IDLE, ADDR, DATA, DRAIN, DONE, ERROR.
- IDLE: on the first non-reset cycle, latch address/length for the selected lane. Go to ERROR if any of:
  - router is not one-hot;
  - address[1:0] ≠ 0;
  - length = 0.
- Burst length = min(PARAM_DATA_ALIGN − (((addr>>2)+offset) & (PARAM_DATA_ALIGN−1)), length − offset).
  - offset counts words already requested.
  - Computed in 32 bits, then truncated to 9 bits.
- ADDR:
  - ARVALID asserts only when (PARAM_FIFO_DEPTH − fifo_count) ≥ burst length.
  - ARADDR = addr + 4·offset, stable while ARVALID.
  - On ARVALID && ARREADY: deassert ARVALID next cycle, offset += len, beat counter cleared, go to DATA.
  - Only one burst is outstanding at a time.
- DATA:
  - RREADY = 1. Space is reserved, so the FIFO cannot overflow.
  - Each RVALID beat pushes RDATA into the FIFO and increments the beat counter.
  - RRESP ≥ 2'b10 → ERROR.
  - RLAST on a beat ≠ final, or missing on the final beat → ERROR.
  - After the final beat: if offset < length go to ADDR, else go to DRAIN.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - First-word latency: a word pushed at edge N is visible as valid after edge N.
  - Pops are accepted during ADDR, DATA and DRAIN.
- DRAIN: when the FIFO is empty, go to DONE.
- DONE and ERROR hold until reset.
  - o_wire_done = (state==DONE).
  - o_wire_error = (state==ERROR).
  - ARVALID, RREADY and valid are all 0 in both states.
- Timeout:
  - 16-bit counter, cleared on any AR handshake, R beat or pop; increments otherwise in ADDR/DATA/DRAIN.
  - Reaching 65535 → ERROR.
- Ordering: words appear in address order. Lanes not selected have valid = 0 and data = 0.

Test Plan:
- Single aligned burst:
  - Stimulus: addr 0x1000, len 5, router 4'b0001, next held 1.
  - Response: one AR with ARADDR 0x1000, ARLEN 4. RLAST on beat 5. Five words appear on lane 0 in order, then done = 1.
- Alignment split:
  - Stimulus: addr 0x1038, len 20, PARAM_DATA_ALIGN 16, router 4'b0100.
  - Response: three ARs: (0x1038, ARLEN 1), (0x1040, ARLEN 15), (0x1080, ARLEN 1). Data appears on the lane-2 slice only.
- Backpressure:
  - Stimulus: len 100, next held 0.
  - Response: AR issue stops once the FIFO holds 64 words. Raising next resumes AR issue, all 100 words arrive in order, then done.
- Bad start:
  - Stimulus: addr 0x1002, or len 0, or router 4'b0011.
  - Response: error = 1 on the second cycle; ARVALID never asserts.
- Bus error:
  - Stimulus: RRESP = 2'b10 on beat 3, or RLAST early on beat 2 of a 4-beat burst.
  - Response: error = 1; no further AR.
- Mid-burst reset:
  - Stimulus: reset asserted during DATA.
  - Response: next cycle all outputs are 0 and the FIFO is empty. After release a fresh transfer runs and completes.
